// File: rtl/booth_radix4_mul.sv
// booth_radix4_mul: sequential radix-4 (modified Booth) multiplier.
// Retires two multiplier bits per clock; signed or unsigned operands.
module booth_radix4_mul #(
  parameter int WIDTH = 24
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);
  localparam int EW = WIDTH + 2;
  localparam int AW = WIDTH + 4;
  localparam int N  = WIDTH / 2 + 1;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [EW-1:0]      m_q, m_d;
  logic [EW-1:0]      q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [AW-1:0] m_ext;
  logic [AW-1:0] addend;
  logic [AW-1:0] sum;
  logic [AW-1:0] acc_sh;
  logic [EW-1:0] q_sh;
  logic [2:0]    digit;

  // Two guard bits on M and two more on ACC keep +-2M and every sum exact.
  always_comb begin
    m_ext = {{(AW-EW){m_q[EW-1]}}, m_q};
    digit = {q_q[1:0], qm1_q};
    case (digit)
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = m_ext << 1;
      3'b100:         addend = -(m_ext << 1);
      3'b101, 3'b110: addend = -m_ext;
      default:        addend = '0;
    endcase
    sum    = acc_q + addend;
    acc_sh = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_sh   = {sum[1:0], q_q[EW-1:2]};
  end

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    q_d      = q_q;
    qm1_d    = qm1_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = signed_mode ? {{2{y[WIDTH-1]}}, y} : {2'b00, y};
          q_d     = signed_mode ? {{2{x[WIDTH-1]}}, x} : {2'b00, x};
          qm1_d   = 1'b0;
          acc_d   = '0;
          cnt_d   = CW'(N);
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = acc_sh;
        q_d   = q_sh;
        qm1_d = q_q[1];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = {acc_sh[WIDTH-3:0], q_sh};
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      m_q      <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      q_q      <= q_d;
      qm1_q    <= qm1_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
endmodule

// File: tb/tb_booth_radix4_mul.sv
// tb_booth_radix4_mul: directed and randomized checks of the
// radix-4 Booth multiplier at WIDTH=24 and WIDTH=8.
module tb_booth_radix4_mul;
  localparam int N = 24 / 2 + 1;
  localparam int N8 = 8 / 2 + 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic sm = 1'b0;
  logic [23:0] x = '0;
  logic [23:0] y = '0;
  logic busy, done;
  logic [47:0] result;

  logic start8 = 1'b0;
  logic sm8 = 1'b0;
  logic [7:0] x8 = '0;
  logic [7:0] y8 = '0;
  logic busy8, done8;
  logic [15:0] result8;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  booth_radix4_mul #(.WIDTH(24)) dut (
    .clock(clock), .reset(reset), .start(start),
    .signed_mode(sm), .x(x), .y(y),
    .busy(busy), .done(done), .result(result)
  );

  booth_radix4_mul #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8),
    .signed_mode(sm8), .x(x8), .y(y8),
    .busy(busy8), .done(done8), .result(result8)
  );

  function automatic logic [47:0] ref24(
    input logic [23:0] a, input logic [23:0] b, input logic s);
    longint pa, pb;
    pa = s ? longint'($signed(a)) : longint'({40'b0, a});
    pb = s ? longint'($signed(b)) : longint'({40'b0, b});
    return 48'(pa * pb);
  endfunction

  function automatic logic [15:0] ref8(
    input logic [7:0] a, input logic [7:0] b, input logic s);
    int pa, pb;
    pa = s ? int'($signed(a)) : int'({24'b0, a});
    pb = s ? int'($signed(b)) : int'({24'b0, b});
    return 16'(pa * pb);
  endfunction

  // Runs one operation; lat is the cycle index (1 = cycle after accept) of done.
  task automatic do_op24(input logic [23:0] a, input logic [23:0] b,
                         input logic s, output logic [47:0] r,
                         output int lat, output int bc);
    int g;
    @(negedge clock);
    x = a; y = b; sm = s; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 1;
    bc = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(posedge clock); #1;
      lat++;
      if (busy) bc++;
    end
    r = result;
    g = 0;
    while (busy && g < 5) begin
      @(posedge clock); #1;
      g++;
      if (busy) bc++;
    end
  endtask

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b,
                        input logic s, output logic [15:0] r,
                        output int lat);
    int g;
    @(negedge clock);
    x8 = a; y8 = b; sm8 = s; start8 = 1'b1;
    @(posedge clock); #1;
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 30) begin
      @(posedge clock); #1;
      lat++;
    end
    r = result8;
    g = 0;
    while (busy8 && g < 5) begin
      @(posedge clock); #1;
      g++;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b done=%b expected 0 0", busy, done);
    end
    checks++;
    if (result !== 48'h0) begin
      errors++;
      $display("FAIL reset_result: got %h expected 0", result);
    end
    checks++;
    if (result8 !== 16'h0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_w8: result8=%h busy8=%b expected 0 0", result8, busy8);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [47:0] r;
    int lat, bc;
    do_op24(24'hFFFFF9, 24'h000007, 1'b1, r, lat, bc);
    checks++;
    if (r !== 48'hFFFF_FFFF_FFCF) begin
      errors++;
      $display("FAIL neg7x7: got %h expected ffffffffffcf", r);
    end
    checks++;
    if (lat !== N + 1) begin
      errors++;
      $display("FAIL done_latency: got %0d expected %0d", lat, N + 1);
    end
    checks++;
    if (bc !== N + 1) begin
      errors++;
      $display("FAIL busy_cycles: got %0d expected %0d", bc, N + 1);
    end
    do_op24(24'hFFFFFF, 24'hFFFFFF, 1'b0, r, lat, bc);
    checks++;
    if (r !== 48'hFFFF_FE00_0001) begin
      errors++;
      $display("FAIL max_unsigned: got %h expected fffffe000001", r);
    end
    do_op24(24'hFFFFFF, 24'hFFFFFF, 1'b1, r, lat, bc);
    checks++;
    if (r !== 48'h0000_0000_0001) begin
      errors++;
      $display("FAIL minus1_sq: got %h expected 000000000001", r);
    end
    do_op24(24'h800000, 24'h800000, 1'b1, r, lat, bc);
    checks++;
    if (r !== 48'h4000_0000_0000) begin
      errors++;
      $display("FAIL min_sq: got %h expected 400000000000", r);
    end
    do_op24(24'h800000, 24'h7FFFFF, 1'b1, r, lat, bc);
    checks++;
    if (r !== 48'hC000_0080_0000) begin
      errors++;
      $display("FAIL min_x_max: got %h expected c00000800000", r);
    end
  endtask

  task automatic test_width8();
    logic [15:0] r;
    int lat;
    do_op8(8'h80, 8'h7F, 1'b1, r, lat);
    checks++;
    if (r !== 16'hC080) begin
      errors++;
      $display("FAIL w8_min_x_max: got %h expected c080", r);
    end
    checks++;
    if (lat !== N8 + 1) begin
      errors++;
      $display("FAIL w8_latency: got %0d expected %0d", lat, N8 + 1);
    end
  endtask

  task automatic test_random();
    logic [47:0] r;
    logic [15:0] r8;
    logic [23:0] a, b;
    logic [7:0] a8, b8;
    logic s;
    int lat, bc;
    for (int i = 0; i < 1000; i++) begin
      a = 24'($urandom);
      b = 24'($urandom);
      s = 1'(i & 1);
      do_op24(a, b, s, r, lat, bc);
      checks++;
      if (r !== ref24(a, b, s) || lat !== N + 1) begin
        errors++;
        $display("FAIL rand24: x=%h y=%h s=%b got %h lat %0d expected %h lat %0d",
                 a, b, s, r, lat, ref24(a, b, s), N + 1);
      end
    end
    for (int i = 0; i < 300; i++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      s = 1'($urandom_range(0, 1));
      do_op8(a8, b8, s, r8, lat);
      checks++;
      if (r8 !== ref8(a8, b8, s)) begin
        errors++;
        $display("FAIL rand8: x=%h y=%h s=%b got %h expected %h",
                 a8, b8, s, r8, ref8(a8, b8, s));
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [47:0] r0, exp_a;
    logic stable, moved;
    int cyc;
    r0 = result;
    exp_a = ref24(24'h123456, 24'hFEDCBA, 1'b1);
    stable = 1'b1;
    @(negedge clock);
    x = 24'h123456; y = 24'hFEDCBA; sm = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 1;
    repeat (3) begin
      @(posedge clock); #1;
      cyc++;
      if (result !== r0) stable = 1'b0;
    end
    @(negedge clock);
    x = 24'h00ABCD; y = 24'h000077; sm = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    while (!done && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
      if (!done && result !== r0) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin
      errors++;
      $display("FAIL result_hold_calc: result moved before completion, held %h", r0);
    end
    checks++;
    if (result !== exp_a || !done) begin
      errors++;
      $display("FAIL ignore_start: got %h done %b expected %h done 1",
               result, done, exp_a);
    end
    moved = 1'b0;
    repeat (4) begin
      @(posedge clock); #1;
      if (result !== exp_a || busy) moved = 1'b1;
    end
    checks++;
    if (moved !== 1'b0) begin
      errors++;
      $display("FAIL hold_after_done: result=%h busy=%b expected %h busy 0",
               result, busy, exp_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] r1, r2;
    int cyc, nd, t1, t2;
    nd = 0; t1 = 0; t2 = 0; r1 = '0; r2 = '0;
    @(negedge clock);
    x = 24'hC0FFEE; y = 24'h00BEEF; sm = 1'b0; start = 1'b1;
    for (cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clock); #1;
      if (done) begin
        if (nd == 0) begin
          t1 = cyc; r1 = result;
          x = 24'h800001; y = 24'hFFFF00; sm = 1'b1;
          nd = 1;
        end else begin
          t2 = cyc; r2 = result;
          break;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (r1 !== ref24(24'hC0FFEE, 24'h00BEEF, 1'b0)) begin
      errors++;
      $display("FAIL b2b_first: got %h expected %h",
               r1, ref24(24'hC0FFEE, 24'h00BEEF, 1'b0));
    end
    checks++;
    if (r2 !== ref24(24'h800001, 24'hFFFF00, 1'b1)) begin
      errors++;
      $display("FAIL b2b_second: got %h expected %h",
               r2, ref24(24'h800001, 24'hFFFF00, 1'b1));
    end
    checks++;
    if (t1 !== N + 1 || t2 - t1 !== N + 2) begin
      errors++;
      $display("FAIL b2b_spacing: first %0d gap %0d expected %0d gap %0d",
               t1, t2 - t1, N + 1, N + 2);
    end
    repeat (3) @(posedge clock);
  endtask

  task automatic test_reset_mid();
    logic [47:0] r;
    int lat, bc;
    @(negedge clock);
    x = 24'h000321; y = 24'h000123; sm = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 48'h0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h expected 0 0 0",
               busy, done, result);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0 || result !== 48'h0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b result=%h expected 0 0", busy, result);
    end
    do_op24(24'hF00D00, 24'h0ACE01, 1'b1, r, lat, bc);
    checks++;
    if (r !== ref24(24'hF00D00, 24'h0ACE01, 1'b1) || lat !== N + 1) begin
      errors++;
      $display("FAIL after_reset: got %h lat %0d expected %h lat %0d",
               r, lat, ref24(24'hF00D00, 24'h0ACE01, 1'b1), N + 1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_width8();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
